// File: rtl/ppg_cal_ctrl_if.sv
// Analog front-end bus of the PPG calibration controller.
// ADC sample in; DC-comp DAC, PGA gain and LED drive out.
interface ppg_cal_ctrl_if #(
   parameter int ADC_W  = 8,
   parameter int DC_W   = 7,
   parameter int GAIN_W = 4,
   parameter int N_CH   = 2,
   parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
   logic [ADC_W-1:0]  ADC;
   logic [DC_W-1:0]   DC_Comp;
   logic [GAIN_W-1:0] PGA_Gain;
   logic [N_CH-1:0]   led_en;
   logic [CH_W-1:0]   ch_sel;
   logic              slot_end;

   modport master (
      input  ADC,
      output DC_Comp, PGA_Gain, led_en, ch_sel, slot_end
   );

   modport slave (
      output ADC,
      input  DC_Comp, PGA_Gain, led_en, ch_sel, slot_end
   );
endinterface

// File: rtl/ppg_cal_ctrl.sv
// Multi-channel PPG DC-comp / PGA calibration and LED multiplexer.
// CAL_GAIN_SEARCH_EN builds the per-channel PGA gain search.
module ppg_cal_ctrl #(
   parameter int ADC_W  = 8,
   parameter int DC_W   = 7,
   parameter int GAIN_W = 4,
   parameter int N_CH   = 2,
   parameter int TOL    = 2,
   parameter int SETTLE = 4,
   parameter int WIN    = 16,
   parameter int SWING  = 64,
   parameter int SLOT   = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            Find_Setting,
   ppg_cal_ctrl_if.master  afe,
   output logic            busy,
   output logic            cal_done,
   output logic [N_CH-1:0] cal_err
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CNT_MAX = (SLOT > WIN)
      ? ((SLOT > SETTLE) ? SLOT : SETTLE)
      : ((WIN > SETTLE) ? WIN : SETTLE);
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   localparam logic [ADC_W-1:0] MID = ADC_W'((1 << (ADC_W-1)) - 1);
   localparam logic [ADC_W-1:0] TOL_V = ADC_W'(TOL);
   localparam logic [DC_W-1:0] DC_MID = DC_W'(1 << (DC_W-1));
   localparam logic [DC_W-1:0] STEP0 = DC_W'(1 << (DC_W-2));
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
   localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT - 1);
`ifdef CAL_GAIN_SEARCH_EN
   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN - 1);
   localparam logic [ADC_W-1:0] SWING_V = ADC_W'(SWING);
`else
   localparam logic [GAIN_W-1:0] GN_DEF = GAIN_W'(1 << (GAIN_W-1));
`endif

   if (N_CH < 1 || N_CH > 8 || SETTLE < 1 || WIN < 1 ||
       SLOT < 1 || SWING < 1) begin : g_bad_cfg
      $error("ppg_cal_ctrl: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      IDLE,
      DC_SETTLE,
      DC_SAMPLE,
`ifdef CAL_GAIN_SEARCH_EN
      GN_SETTLE,
      GN_MEASURE,
`endif
      NEXT_CH,
      RUN
   } state_t;

   state_t            r_state, w_state;
   logic [CH_W-1:0]   r_ch, w_ch, w_nch, w_nch_run;
   logic [CNT_W-1:0]  r_cnt, w_cnt, w_cnt_inc;
   logic [DC_W-1:0]   r_step, w_step;
   logic [DC_W-1:0]   r_dc, w_dc;
   logic [GAIN_W-1:0] r_gn, w_gn, w_gn_val;
   logic [N_CH-1:0]   r_led, w_led;
   logic              r_slot_end, w_slot_end;
   logic              r_busy, w_busy;
   logic              r_done, w_done;
   logic [N_CH-1:0]   r_err, w_err;
   logic              w_dc_we, w_gn_we;
   logic              w_start, w_new_cal;
   logic [DC_W-1:0]   r_dc_mem [N_CH];
   logic [GAIN_W-1:0] r_gn_mem [N_CH];

   logic [ADC_W-1:0]  w_abs;
   logic              w_hit;
   logic [DC_W:0]     w_sum;
   logic [DC_W-1:0]   w_dc_up, w_dc_dn;

   assign w_abs = (afe.ADC > MID) ? afe.ADC - MID : MID - afe.ADC;
   assign w_hit = w_abs < TOL_V;
   // DAC code saturates at both rails instead of wrapping
   assign w_sum = {1'b0, r_dc} + {1'b0, r_step};
   assign w_dc_up = w_sum[DC_W] ? '1 : w_sum[DC_W-1:0];
   assign w_dc_dn = (r_dc > r_step) ? r_dc - r_step : '0;
   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_nch_run = (r_ch == CH_LAST) ? '0 : r_ch + CH_W'(1);

`ifdef CAL_GAIN_SEARCH_EN
   logic [ADC_W-1:0] r_min, r_max, w_lo, w_hi, w_range;
   assign w_lo = (r_cnt == '0 || afe.ADC < r_min) ? afe.ADC : r_min;
   assign w_hi = (r_cnt == '0 || afe.ADC > r_max) ? afe.ADC : r_max;
   assign w_range = w_hi - w_lo;
`endif

   function automatic logic [N_CH-1:0] f_onehot(
      input logic [CH_W-1:0] c
   );
      f_onehot = N_CH'(1) << c;
   endfunction

   always_comb begin
      w_state   = r_state;
      w_ch      = r_ch;
      w_cnt     = r_cnt;
      w_step    = r_step;
      w_dc      = r_dc;
      w_gn      = r_gn;
      w_led     = r_led;
      w_busy    = r_busy;
      w_done    = r_done;
      w_err     = r_err;
      w_dc_we   = 1'b0;
      w_gn_we   = 1'b0;
      w_gn_val  = r_gn;
      w_start   = 1'b0;
      w_new_cal = 1'b0;
      w_nch     = '0;
      unique case (r_state)
         IDLE: begin
            if (Find_Setting) begin
               w_start   = 1'b1;
               w_new_cal = 1'b1;
            end
         end
         DC_SETTLE: begin
            if (r_cnt == SET_LAST) begin
               w_state = DC_SAMPLE;
               w_cnt   = '0;
            end else begin
               w_cnt = w_cnt_inc;
            end
         end
         DC_SAMPLE: begin
            if (w_hit || r_step == '0) begin
               w_dc_we = 1'b1;
               if (!w_hit) w_err[r_ch] = 1'b1;
`ifdef CAL_GAIN_SEARCH_EN
               w_state = GN_SETTLE;
               w_cnt   = '0;
               w_gn    = '0;
`else
               w_gn_we  = 1'b1;
               w_gn_val = GN_DEF;
               w_state  = NEXT_CH;
`endif
            end else begin
               w_dc    = (afe.ADC > MID) ? w_dc_up : w_dc_dn;
               w_step  = r_step >> 1;
               w_state = DC_SETTLE;
               w_cnt   = '0;
            end
         end
`ifdef CAL_GAIN_SEARCH_EN
         GN_SETTLE: begin
            if (r_cnt == SET_LAST) begin
               w_state = GN_MEASURE;
               w_cnt   = '0;
            end else begin
               w_cnt = w_cnt_inc;
            end
         end
         GN_MEASURE: begin
            w_cnt = w_cnt_inc;
            if (r_cnt == WIN_LAST) begin
               w_cnt = '0;
               if (w_range < SWING_V && r_gn != '1) begin
                  w_gn    = r_gn + GAIN_W'(1);
                  w_state = GN_SETTLE;
               end else begin
                  w_gn_we = 1'b1;
                  w_state = NEXT_CH;
               end
            end
         end
`endif
         NEXT_CH: begin
            if (r_ch == CH_LAST) begin
               w_state = RUN;
               w_busy  = 1'b0;
               w_done  = 1'b1;
               w_ch    = '0;
               w_cnt   = '0;
               w_dc    = r_dc_mem[0];
               w_gn    = r_gn_mem[0];
               w_led   = f_onehot('0);
            end else begin
               w_start = 1'b1;
               w_nch   = r_ch + CH_W'(1);
            end
         end
         RUN: begin
            if (r_cnt != SLOT_LAST) begin
               w_cnt = w_cnt_inc;
            end else if (Find_Setting) begin
               w_start   = 1'b1;
               w_new_cal = 1'b1;
            end else begin
               w_cnt = '0;
               w_ch  = w_nch_run;
               w_dc  = r_dc_mem[w_nch_run];
               w_gn  = r_gn_mem[w_nch_run];
               w_led = f_onehot(w_nch_run);
            end
         end
         default: w_state = IDLE;
      endcase
      // Every channel search starts from mid-scale with zero gain
      if (w_start) begin
         w_state = DC_SETTLE;
         w_ch    = w_nch;
         w_cnt   = '0;
         w_dc    = DC_MID;
         w_step  = STEP0;
         w_gn    = '0;
         w_led   = f_onehot(w_nch);
      end
      if (w_new_cal) begin
         w_busy = 1'b1;
         w_done = 1'b0;
         w_err  = '0;
      end
      w_slot_end = (w_state == RUN) && (w_cnt == SLOT_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_ch       <= '0;
         r_cnt      <= '0;
         r_step     <= STEP0;
         r_dc       <= DC_MID;
         r_gn       <= '0;
         r_led      <= '0;
         r_slot_end <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= '0;
         for (int i = 0; i < N_CH; i++) begin
            r_dc_mem[i] <= DC_MID;
            r_gn_mem[i] <= '0;
         end
      end else begin
         r_state    <= w_state;
         r_ch       <= w_ch;
         r_cnt      <= w_cnt;
         r_step     <= w_step;
         r_dc       <= w_dc;
         r_gn       <= w_gn;
         r_led      <= w_led;
         r_slot_end <= w_slot_end;
         r_busy     <= w_busy;
         r_done     <= w_done;
         r_err      <= w_err;
         if (w_dc_we) r_dc_mem[r_ch] <= r_dc;
         if (w_gn_we) r_gn_mem[r_ch] <= w_gn_val;
      end
   end

`ifdef CAL_GAIN_SEARCH_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_min <= '0;
         r_max <= '0;
      end else if (r_state == GN_MEASURE) begin
         r_min <= w_lo;
         r_max <= w_hi;
      end
   end
`endif

   assign afe.DC_Comp  = r_dc;
   assign afe.PGA_Gain = r_gn;
   assign afe.led_en   = r_led;
   assign afe.ch_sel   = r_ch;
   assign afe.slot_end = r_slot_end;
   assign busy         = r_busy;
   assign cal_done     = r_done;
   assign cal_err      = r_err;
endmodule

// File: tb/tb_ppg_cal_ctrl.sv
// Directed bench for ppg_cal_ctrl: 3 channels, default widths/timing.
// AFE model drives ADC from the DAC code, gain and selected channel.
module tb_ppg_cal_ctrl;
   localparam int N_CH   = 3;
   localparam int SETTLE = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       Find_Setting = 1'b0;
   logic       busy, cal_done;
   logic [2:0] cal_err;

   int n_cmp = 0;
   int n_bad = 0;

   ppg_cal_ctrl_if #(.N_CH(N_CH)) afe ();

   ppg_cal_ctrl #(.N_CH(N_CH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Find_Setting (Find_Setting),
      .afe          (afe),
      .busy         (busy),
      .cal_done     (cal_done),
      .cal_err      (cal_err)
   );

   always #5 clk = ~clk;

   // ch0: ADC falls 2 LSB per DAC code, centred at code 40, plus a
   // square swing of 10*(gain+1) once the code has settled.
   // ch1: ADC stuck at 255. ch2: same DC curve as ch0, no swing.
   logic       stuck0 = 1'b0;
   logic       tog = 1'b0;
   logic [6:0] prev_dc = '0;
   int         run_len = 0;
   int         m_len, m_d;

   always @(posedge clk) begin
      prev_dc <= afe.DC_Comp;
      run_len <= (afe.DC_Comp == prev_dc) ? run_len + 1 : 0;
      tog     <= ~tog;
   end

   always_comb begin
      m_len = (afe.DC_Comp == prev_dc) ? run_len + 1 : 0;
      m_d = 127 - 2 * (int'(afe.DC_Comp) - 40);
      if (afe.ch_sel == 2'd0 && m_len > SETTLE && tog)
         m_d = m_d + 10 * (int'(afe.PGA_Gain) + 1);
      if (afe.ch_sel == 2'd1 || (stuck0 && afe.ch_sel == 2'd0))
         m_d = 255;
      if (m_d > 255) m_d = 255;
      if (m_d < 0) m_d = 0;
      afe.ADC = 8'(m_d);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step_dc(input string tag, input int exp);
      logic [6:0] last;
      int n;
      last = afe.DC_Comp;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (afe.DC_Comp == last && n < 20);
      chk({tag, "_val"}, afe.DC_Comp, exp);
      chk({tag, "_gap"}, n, SETTLE + 1);
   endtask

   task automatic wait_ch(input string tag, input int c);
      int n;
      n = 0;
      while (afe.ch_sel != c && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, afe.ch_sel, c);
   endtask

   task automatic wait_slot_end(input string tag, input int gap);
      int n;
      n = 0;
      while (!afe.slot_end && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(tag, n, gap);
   endtask

   int seq0 [4] = '{64, 32, 48, 40};
   int seq1 [7] = '{64, 96, 112, 120, 124, 126, 127};
   int run_dc [3] = '{40, 127, 40};
`ifdef CAL_GAIN_SEARCH_EN
   int run_gn [3] = '{6, 15, 15};
`else
   int run_gn [3] = '{8, 8, 8};
`endif

   initial begin
      int n;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_dc", afe.DC_Comp, 64);
      chk("rst_gain", afe.PGA_Gain, 0);
      chk("rst_led", afe.led_en, 0);
      chk("rst_ch", afe.ch_sel, 0);
      chk("rst_slot", afe.slot_end, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", cal_done, 0);
      chk("rst_err", cal_err, 0);
      repeat (3) @(negedge clk);
      chk("idle_busy", busy, 0);

      Find_Setting = 1'b1;
      @(negedge clk);
      Find_Setting = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_led", afe.led_en, 3'b001);
      chk("start_dc", afe.DC_Comp, 64);
      for (int i = 1; i < 4; i++)
         step_dc($sformatf("ch0_dc%0d", i), seq0[i]);

      wait_ch("to_ch1", 1);
      chk("ch1_dc0", afe.DC_Comp, 64);
      chk("ch1_led", afe.led_en, 3'b010);
      chk("ch0_err", cal_err, 0);
      for (int i = 1; i < 7; i++)
         step_dc($sformatf("ch1_dc%0d", i), seq1[i]);

      wait_ch("to_ch2", 2);
      chk("ch1_err", cal_err, 3'b010);

      n = 0;
      while (!cal_done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("cal_done", cal_done, 1);
      chk("run_busy", busy, 0);
      chk("run_err", cal_err, 3'b010);

      for (int s = 0; s < 4; s++) begin
         int c;
         c = s % 3;
         chk($sformatf("run%0d_ch", s), afe.ch_sel, c);
         chk($sformatf("run%0d_led", s), afe.led_en, 1 << c);
         chk($sformatf("run%0d_dc", s), afe.DC_Comp, run_dc[c]);
         chk($sformatf("run%0d_gn", s), afe.PGA_Gain, run_gn[c]);
         chk($sformatf("run%0d_se0", s), afe.slot_end, 0);
         wait_slot_end($sformatf("run%0d_slot", s), 31);
         @(negedge clk);
      end

      repeat (10) @(negedge clk);
      Find_Setting = 1'b1;
      @(negedge clk);
      Find_Setting = 1'b0;
      chk("pulse_busy", busy, 0);
      wait_slot_end("pulse_slot", 20);
      @(negedge clk);
      chk("pulse_ch", afe.ch_sel, 2);
      chk("pulse_idle", busy, 0);

      repeat (5) @(negedge clk);
      Find_Setting = 1'b1;
      stuck0 = 1'b1;
      wait_slot_end("rc_slot", 26);
      @(negedge clk);
      chk("rc_busy", busy, 1);
      chk("rc_done", cal_done, 0);
      chk("rc_ch", afe.ch_sel, 0);
      chk("rc_err", cal_err, 0);
      chk("rc_dc", afe.DC_Comp, 64);
      chk("rc_gain", afe.PGA_Gain, 0);
      chk("rc_led", afe.led_en, 3'b001);
      step_dc("rc_dc1", 96);

      rst_n = 1'b0;
      @(negedge clk);
      chk("rst2_dc", afe.DC_Comp, 64);
      chk("rst2_led", afe.led_en, 0);
      chk("rst2_busy", busy, 0);
      chk("rst2_gain", afe.PGA_Gain, 0);
      chk("rst2_done", cal_done, 0);
      rst_n = 1'b1;
      Find_Setting = 1'b0;
      repeat (8) @(negedge clk);
      chk("idle2_busy", busy, 0);
      chk("idle2_dc", afe.DC_Comp, 64);
      chk("idle2_led", afe.led_en, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
